prim_timer_hard: RTL and testbench
==================================

PRIM_TIMER_HARD -- requirements
Module: prim_timer_hard

Interface
REQ-001 Parameter Width, default 16: counter width in bits; legal range 2..32.
REQ-002 clk_i  input  1  single clock; all state is updated on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 start_i  input  1  load load_val_i and begin countdown; honoured only in IDLE.
REQ-005 load_val_i  input  Width  countdown length in cycles; sampled only on an accepted start.
REQ-006 periodic_i  input  1  sampled with start_i; 1 selects auto-reload, 0 selects one-shot.
REQ-007 stop_i  input  1  abort; RUN or EXPIRE -> IDLE.
REQ-008 ack_i  input  1  acknowledges expired_o; honoured only in EXPIRE.
REQ-009 cnt_o  output  Width  primary (down-counting) counter value.
REQ-010 busy_o  output  1  high in RUN and EXPIRE.
REQ-011 expired_o  output  1  level request, high in EXPIRE until acknowledged.
REQ-012 err_o  output  1  registered, sticky integrity error.

Function
REQ-013 The block SHALL hold a cross-counter pair: primary P counts down; secondary S counts up; P+S SHALL equal 2**Width-1 at all times.
REQ-014 States are IDLE, RUN, EXPIRE and ERROR, with sparse encoding (pairwise Hamming distance >=3).
REQ-015 IDLE: P=0 and S=all-ones; an accepted start at edge k SHALL load P=N and S=~N, latch reload R=N plus a complement copy ~R, latch periodic_i, and enter RUN, or enter EXPIRE if N=0.
REQ-016 RUN: each edge SHALL apply P-1 and S+1; the edge that makes P=0 SHALL also enter EXPIRE, so expired_o is visible after edge k+N.
REQ-017 P SHALL never decrement below 0 and S SHALL never increment above all-ones (saturate; no wrap-around).
REQ-018 EXPIRE: P holds at 0; ack_i at edge j with periodic set SHALL reload P=R, S=~R and enter RUN, giving the next expiry at edge j+R; R=0 stays in EXPIRE; ack with one-shot SHALL enter IDLE.
REQ-019 stop_i in RUN or EXPIRE SHALL enter IDLE with P=0 and S=all-ones at the next edge.
REQ-020 Priority: error > stop_i > ack_i; start_i outside IDLE is ignored; in IDLE, stop_i and ack_i are ignored.
REQ-021 Error sources: P+S != 2**Width-1; R xor ~R-copy != all-ones; state register holds an invalid encoding.
REQ-022 Any error source at edge e SHALL enter ERROR and set err_o from edge e; ERROR is terminal until rst_i.
REQ-023 In ERROR: busy_o=0 and expired_o=0; cnt_o keeps its last value; all inputs are ignored.
REQ-024 The sum check SHALL use Width+1-bit arithmetic so carry-out is detected.

Reset
REQ-025 rst_i asserted at an edge SHALL force IDLE, P=0, S=all-ones, R=0, ~R-copy=all-ones and periodic=0 regardless of other inputs, including mid-RUN, in EXPIRE and in ERROR.
REQ-026 Reset values: cnt_o=0, busy_o=0, expired_o=0, err_o=0.

Structure
REQ-027 Package prim_timer_pkg SHALL hold the sparse state enum and its encodings, exported for verification.
REQ-028 One sub-module, prim_timer_xcnt, SHALL implement one saturating up/down counter slice with load; it is instantiated twice, once in the down direction and once in the up direction.
REQ-029 Integrity checking and the FSM SHALL live in the top level.

Verification (Width=8)
REQ-030 Reset: rst_i high for 2 cycles during RUN -> cnt_o=0, busy_o=0, expired_o=0, err_o=0, state IDLE.
REQ-031 One-shot: start_i with load 5 at edge k -> cnt_o goes 5,4,3,2,1,0; expired_o rises after edge k+5; ack -> IDLE, busy_o=0.
REQ-032 Periodic: load 3; ack at the first cycle of each EXPIRE -> expired_o high for 1 cycle every 4 cycles; cnt_o reloads to 3.
REQ-033 Abort and corners: stop_i at cnt_o=2 -> IDLE, cnt_o=0, no expiry; start with load 0 -> EXPIRE after the accepting edge; stop_i and ack_i together in EXPIRE -> IDLE.
REQ-034 Fault: force S bit 0 flip in RUN -> err_o=1 after that edge, state ERROR, expired_o held 0; start_i ignored until rst_i.
REQ-035 Fault: force the state register to an invalid encoding, or corrupt the R copy -> err_o=1 and ERROR.

Source files
------------

// File: rtl/prim_timer_pkg.sv
// Shared definitions for the hardened timer: sparse state encodings and the
// helper that recognises a legal state word.
package prim_timer_pkg;

  localparam int StateWidth = 5;

  // Every pair of codes differs in at least three bits, so a single upset
  // can never turn one legal state into another.
  typedef enum logic [StateWidth-1:0] {
    ST_IDLE   = 5'b00011,
    ST_RUN    = 5'b01100,
    ST_EXPIRE = 5'b10101,
    ST_ERROR  = 5'b11010
  } state_e;

  function automatic logic state_is_valid(input state_e s);
    logic ok;
    case (s)
      ST_IDLE, ST_RUN, ST_EXPIRE, ST_ERROR: ok = 1'b1;
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/prim_timer_hard_if.sv
// Control and status bundle of the hardened timer.
interface prim_timer_hard_if #(
  parameter int Width = 16
);

  logic             start_i;
  logic [Width-1:0] load_val_i;
  logic             periodic_i;
  logic             stop_i;
  logic             ack_i;
  logic [Width-1:0] cnt_o;
  logic             busy_o;
  logic             expired_o;
  logic             err_o;

  modport master (
    output start_i,
    output load_val_i,
    output periodic_i,
    output stop_i,
    output ack_i,
    input  cnt_o,
    input  busy_o,
    input  expired_o,
    input  err_o
  );

  modport slave (
    input  start_i,
    input  load_val_i,
    input  periodic_i,
    input  stop_i,
    input  ack_i,
    output cnt_o,
    output busy_o,
    output expired_o,
    output err_o
  );

endinterface

// File: rtl/prim_timer_xcnt.sv
// One slice of the cross-counter pair: a loadable counter that saturates at
// zero (down direction) or at all-ones (up direction) instead of wrapping.
module prim_timer_xcnt #(
  parameter int               Width    = 16,
  parameter bit               CountUp  = 1'b0,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] One   = Width'(1);
  localparam logic [Width-1:0] Limit = CountUp ? {Width{1'b1}} : {Width{1'b0}};

  logic [Width-1:0] cnt_q;
  logic             at_limit;

  assign at_limit = (cnt_q == Limit);

  // A load wins over counting; counting stops dead at the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= ResetVal;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && !at_limit) begin
      cnt_q <= CountUp ? (cnt_q + One) : (cnt_q - One);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prim_timer_hard.sv
// Hardened countdown timer: a down/up cross-counter pair, a duplicated reload
// value and a sparse FSM, all continuously checked; any mismatch is terminal.
module prim_timer_hard
  import prim_timer_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  prim_timer_hard_if.slave bus
);

  localparam logic [Width-1:0] AllOnes = {Width{1'b1}};
  localparam logic [Width:0]   SumGood = {1'b0, AllOnes};
  localparam logic [Width-1:0] One     = Width'(1);

  state_e           state_q, state_d;
  logic [Width-1:0] p_cnt, s_cnt;
  logic [Width-1:0] reload_q, reload_n_q;
  logic             periodic_q;
  logic             err_q;

  logic             cnt_load;
  logic [Width-1:0] cnt_load_val;
  logic             cnt_en;
  logic             reload_we;

  logic [Width:0]   sum;
  logic             sum_err, reload_err, state_err, any_err;

  prim_timer_xcnt #(
    .Width    (Width),
    .CountUp  (1'b0),
    .ResetVal ({Width{1'b0}})
  ) u_dn (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .cnt_o      (p_cnt)
  );

  prim_timer_xcnt #(
    .Width    (Width),
    .CountUp  (1'b1),
    .ResetVal ({Width{1'b1}})
  ) u_up (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (~cnt_load_val),
    .en_i       (cnt_en),
    .cnt_o      (s_cnt)
  );

  // One extra bit on the sum so a carry out of the pair is not masked.
  assign sum        = {1'b0, p_cnt} + {1'b0, s_cnt};
  assign sum_err    = (sum != SumGood);
  assign reload_err = ((reload_q ^ reload_n_q) != AllOnes);
  assign state_err  = !state_is_valid(state_q);
  assign any_err    = sum_err | reload_err | state_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      reload_q   <= '0;
      reload_n_q <= AllOnes;
      periodic_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | any_err;
      if (reload_we) begin
        reload_q   <= bus.load_val_i;
        reload_n_q <= ~bus.load_val_i;
        periodic_q <= bus.periodic_i;
      end
    end
  end

  // Loading zero into the pair is how IDLE gets P=0 and S=all-ones; a detected
  // error freezes the counters so cnt_o shows the value at the moment of failure.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    reload_we    = 1'b0;

    if (any_err) begin
      state_d = ST_ERROR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            cnt_load     = 1'b1;
            cnt_load_val = bus.load_val_i;
            reload_we    = 1'b1;
            state_d      = (bus.load_val_i == '0) ? ST_EXPIRE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.stop_i) begin
            cnt_load = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cnt_en = 1'b1;
            if (p_cnt <= One) begin
              state_d = ST_EXPIRE;
            end
          end
        end
        ST_EXPIRE: begin
          if (bus.stop_i) begin
            cnt_load = 1'b1;
            state_d  = ST_IDLE;
          end else if (bus.ack_i) begin
            cnt_load = 1'b1;
            if (periodic_q) begin
              cnt_load_val = reload_q;
              state_d      = (reload_q == '0) ? ST_EXPIRE : ST_RUN;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_ERROR;
        end
      endcase
    end
  end

  assign bus.cnt_o     = p_cnt;
  assign bus.busy_o    = (state_q == ST_RUN) || (state_q == ST_EXPIRE);
  assign bus.expired_o = (state_q == ST_EXPIRE);
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_prim_timer_hard.sv
// Directed and randomized checks of prim_timer_hard (Width=8) against a
// behavioural model of the timer rules, including injected integrity faults.
module tb_prim_timer_hard;
  import prim_timer_pkg::*;

  localparam int W = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_EXPIRE = 2, M_ERROR = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  prim_timer_hard_if #(.Width(W)) bus ();

  prim_timer_hard #(.Width(W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  int         m_mode = M_IDLE;
  logic [W-1:0] m_p  = '0;
  logic [W-1:0] m_r  = '0;
  logic       m_per  = 1'b0;
  logic       m_err  = 1'b0;

  logic [W-1:0] bad_s;
  logic [W-1:0] bad_rn;
  state_e       bad_state;

  // Timer rules: remaining count, reload value and periodic flag per edge.
  task automatic modelStep(input logic st, input logic [W-1:0] ld, input logic pr,
                           input logic sp, input logic ak, input logic rs,
                           input logic flt);
    if (rs) begin
      m_mode = M_IDLE; m_p = '0; m_r = '0; m_per = 1'b0; m_err = 1'b0;
    end else if (m_mode == M_ERROR) begin
      m_mode = M_ERROR;
    end else if (flt) begin
      m_mode = M_ERROR; m_err = 1'b1;
    end else if (m_mode == M_IDLE) begin
      if (st) begin
        m_p = ld; m_r = ld; m_per = pr;
        m_mode = (ld == 0) ? M_EXPIRE : M_RUN;
      end
    end else if (sp) begin
      m_mode = M_IDLE; m_p = '0;
    end else if (m_mode == M_RUN) begin
      m_p = m_p - 1'b1;
      if (m_p == 0) m_mode = M_EXPIRE;
    end else if (ak) begin
      if (m_per) begin
        m_p = m_r;
        m_mode = (m_r == 0) ? M_EXPIRE : M_RUN;
      end else begin
        m_mode = M_IDLE; m_p = '0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic exp_busy, exp_expired;
    exp_busy    = (m_mode == M_RUN) || (m_mode == M_EXPIRE);
    exp_expired = (m_mode == M_EXPIRE);
    checks++;
    assert (bus.cnt_o === m_p) else begin
      failures++;
      $error("[TB] FAIL %s cnt_o: got %0d expected %0d", tag, bus.cnt_o, m_p);
    end
    checks++;
    assert (bus.busy_o === exp_busy) else begin
      failures++;
      $error("[TB] FAIL %s busy_o: got %b expected %b", tag, bus.busy_o, exp_busy);
    end
    checks++;
    assert (bus.expired_o === exp_expired) else begin
      failures++;
      $error("[TB] FAIL %s expired_o: got %b expected %b", tag, bus.expired_o, exp_expired);
    end
    checks++;
    assert (bus.err_o === m_err) else begin
      failures++;
      $error("[TB] FAIL %s err_o: got %b expected %b", tag, bus.err_o, m_err);
    end
  endtask

  task automatic checkState(input string tag, input state_e exp);
    checks++;
    assert (dut.state_q === exp) else begin
      failures++;
      $error("[TB] FAIL %s state: got %b expected %b", tag, dut.state_q, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [W-1:0] ld, input logic pr,
                               input logic sp, input logic ak, input logic rs,
                               input logic flt, input string tag);
    bus.start_i    = st;
    bus.load_val_i = ld;
    bus.periodic_i = pr;
    bus.stop_i     = sp;
    bus.ack_i      = ak;
    rst_i          = rs;
    modelStep(st, ld, pr, sp, ak, rs, flt);
    @(posedge clk_i);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.load_val_i = '0; bus.periodic_i = 1'b0;
    bus.stop_i = 1'b0;  bus.ack_i = 1'b0;

    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "por");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "por");
    checkState("por_state", ST_IDLE);

    // Reset in the middle of a countdown.
    applyStimulus(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_start");
    idleCycle("rst_run");
    applyStimulus(1'b1, 8'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "rst_mid0");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rst_mid1");
    checkState("rst_mid_state", ST_IDLE);

    // One-shot of length 5, then acknowledge.
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "oneshot_start");
    for (int i = 0; i < 5; i++) idleCycle("oneshot_run");
    idleCycle("oneshot_hold");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "oneshot_ack");
    checkState("oneshot_idle", ST_IDLE);

    // Periodic load 3, acknowledged on the first cycle of each expiry.
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "per_start");
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b0, '0, 1'b0, 1'b0, (m_mode == M_EXPIRE), 1'b0, 1'b0, "per_run");
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "per_stop");

    // Abort at count 2.
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "abort_start");
    while (m_p != 8'd2) idleCycle("abort_run");
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "abort_stop");
    idleCycle("abort_after");

    // Zero load expires immediately; stop and ack together leave for IDLE.
    applyStimulus(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "zero_start");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "zero_ack_stay");
    applyStimulus(1'b1, 8'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "stop_ack");
    checkState("stop_ack_state", ST_IDLE);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "idle_stop_ack");

    // Flip S bit 0 during RUN.
    applyStimulus(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sflip_start");
    idleCycle("sflip_run");
    bad_s = (~m_p) ^ 8'h01;
    force dut.u_up.cnt_q = bad_s;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sflip_edge");
    release dut.u_up.cnt_q;
    checkState("sflip_state", ST_ERROR);
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sflip_start_ign");
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "sflip_inputs_ign");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "sflip_rst");
    checkState("sflip_rst_state", ST_IDLE);

    // Illegal state word.
    applyStimulus(1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "bad_state_start");
    bad_state = state_e'(5'b11111);
    force dut.state_q = bad_state;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bad_state_edge");
    release dut.state_q;
    idleCycle("bad_state_after");
    checkState("bad_state_state", ST_ERROR);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "bad_state_rst");

    // Corrupted reload complement.
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "bad_r_start");
    bad_rn = (~m_r) ^ 8'h10;
    force dut.reload_n_q = bad_rn;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bad_r_edge");
    release dut.reload_n_q;
    checkState("bad_r_state", ST_ERROR);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "bad_r_rst");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic r_st, r_pr, r_sp, r_ak, r_rs;
      logic [W-1:0] r_ld;
      r_st = ($urandom_range(0, 3) == 0);
      r_ld = W'($urandom_range(0, 6));
      r_pr = $urandom_range(0, 1) == 1;
      r_sp = ($urandom_range(0, 15) == 0);
      r_ak = ($urandom_range(0, 2) == 0);
      r_rs = ($urandom_range(0, 63) == 0);
      applyStimulus(r_st, r_ld, r_pr, r_sp, r_ak, r_rs, 1'b0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
